spi_xfer_queue: RTL and testbench

Command/data front end sitting directly upstream of `spi_top`. It buffers SPI transfer commands from a host valid/ready stream and issues them one at a time to the SPI master: it drives `req`, `din_master` and `wait_duration`, and waits for `done_tx`/`done_rx`. For read transfers it captures `dout_master` into an RX FIFO, which drains through a second valid/ready stream.

---
 rtl/spi_xfer_queue.sv | 186 ++++++++++++++++++
 tb/tb_spi_xfer_queue.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_queue.sv
// Command/data front end for spi_top: queues host transfer commands, issues them one at a
// time to the SPI master, and buffers bytes received on read transfers in an RX FIFO.
module spi_xfer_queue #(
    parameter int         DATA_W     = 8,
    parameter int         CMD_DEPTH  = 4,
    parameter int         RX_DEPTH   = 4,
    parameter int         GAP_CYCLES = 2,
    parameter logic [7:0] WAIT_DUR   = 8'd10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [1:0]        s_req,
    input  logic [DATA_W-1:0] s_data,
    output logic [1:0]        req,
    output logic [DATA_W-1:0] din_master,
    output logic [7:0]        wait_duration,
    input  logic              done_tx,
    input  logic              done_rx,
    input  logic [DATA_W-1:0] dout_master,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic              err_bad_cmd
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int CW  = DATA_W + 2;
    localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CAW:0]  C_ONE    = 1;
    localparam logic [RAW:0]  R_ONE    = 1;
    localparam logic [GW-1:0] G_ONE    = 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    // Valid/ready: a beat moves on a rising edge where valid and ready are both high;
    // ready depends only on registered FIFO state.

    // ---------------- command FIFO ----------------
    logic [CW-1:0]     cmd_mem [CMD_DEPTH];
    logic [CAW:0]      cmd_wr, cmd_rd;
    logic              cmd_empty, cmd_full, cmd_push, cmd_pop;
    logic [CW-1:0]     cmd_head;
    logic [1:0]        head_req;
    logic [DATA_W-1:0] head_data;

    assign cmd_empty = (cmd_wr == cmd_rd);
    assign cmd_full  = (cmd_wr[CAW] != cmd_rd[CAW]) && (cmd_wr[CAW-1:0] == cmd_rd[CAW-1:0]);
    assign cmd_push  = s_valid && s_ready;
    assign cmd_head  = cmd_mem[cmd_rd[CAW-1:0]];
    assign head_req  = cmd_head[DATA_W +: 2];
    assign head_data = cmd_head[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_wr <= '0;
            cmd_rd <= '0;
        end else begin
            if (cmd_push) cmd_wr <= cmd_wr + C_ONE;
            if (cmd_pop)  cmd_rd <= cmd_rd + C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem[cmd_wr[CAW-1:0]] <= {s_req, s_data};
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [RAW:0]      rx_wr, rx_rd;
    logic              rx_empty, rx_full, rx_push, rx_pop;

    assign rx_empty = (rx_wr == rx_rd);
    assign rx_full  = (rx_wr[RAW] != rx_rd[RAW]) && (rx_wr[RAW-1:0] == rx_rd[RAW-1:0]);
    assign rx_pop   = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wr <= '0;
            rx_rd <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + R_ONE;
            if (rx_pop)  rx_rd <= rx_rd + R_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr[RAW-1:0]] <= dout_master;
    end

    // ---------------- transfer FSM ----------------
    state_t            state, state_n;
    logic [1:0]        req_q, req_n;
    logic [DATA_W-1:0] din_q, din_n;
    logic              tx_seen, tx_seen_n, rx_seen, rx_seen_n;
    logic [GW-1:0]     gap_cnt, gap_n;
    logic              err_q, err_n;
    logic              xfer_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            req_q   <= '0;
            din_q   <= '0;
            tx_seen <= 1'b0;
            rx_seen <= 1'b0;
            gap_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            req_q   <= req_n;
            din_q   <= din_n;
            tx_seen <= tx_seen_n;
            rx_seen <= rx_seen_n;
            gap_cnt <= gap_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        req_n     = req_q;
        din_n     = din_q;
        tx_seen_n = tx_seen;
        rx_seen_n = rx_seen;
        gap_n     = gap_cnt;
        err_n     = err_q;
        cmd_pop   = 1'b0;
        rx_push   = 1'b0;
        xfer_done = 1'b0;
        case (state)
            IDLE: begin
                if (!cmd_empty) begin
                    if (head_req == 2'd0) begin
                        cmd_pop = 1'b1;
                        err_n   = 1'b1;
                    end else if (!rx_full) begin
                        // Issuing only with an RX slot free keeps the single outstanding read safe.
                        cmd_pop   = 1'b1;
                        req_n     = head_req;
                        din_n     = head_data;
                        tx_seen_n = 1'b0;
                        rx_seen_n = 1'b0;
                        state_n   = XFER;
                    end
                end
            end
            XFER: begin
                tx_seen_n = tx_seen | done_tx;
                rx_seen_n = rx_seen | done_rx;
                rx_push   = done_rx && req_q[1] && !rx_seen;
                case (req_q)
                    2'd1:    xfer_done = tx_seen_n;
                    2'd2:    xfer_done = rx_seen_n;
                    2'd3:    xfer_done = tx_seen_n && rx_seen_n;
                    default: xfer_done = 1'b1;
                endcase
                if (xfer_done) begin
                    state_n = GAP;
                    req_n   = 2'd0;
                    gap_n   = GAP_LOAD;
                end
            end
            GAP: begin
                // Lingering done pulses from the master must clear before the next issue.
                if (gap_cnt != '0) gap_n = gap_cnt - G_ONE;
                else if (!done_tx && !done_rx) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign s_ready       = !cmd_full;
    assign m_valid       = !rx_empty;
    assign m_data        = rx_mem[rx_rd[RAW-1:0]];
    assign req           = req_q;
    assign din_master    = din_q;
    assign wait_duration = WAIT_DUR;
    assign busy          = (state != IDLE) || !cmd_empty;
    assign err_bad_cmd   = err_q;

endmodule

// File: tb/tb_spi_xfer_queue.sv
// Bench for spi_xfer_queue: SPI master responder model, command driver, and an RX
// scoreboard fed when the model returns a byte and drained when the DUT presents it.
module tb_spi_xfer_queue;

    localparam int DATA_W     = 8;
    localparam int GAP_CYCLES = 2;
    localparam int BIG        = 1000000;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [1:0]        s_req;
    logic [DATA_W-1:0] s_data;
    logic [1:0]        req;
    logic [DATA_W-1:0] din_master;
    logic [7:0]        wait_duration;
    logic              done_tx;
    logic              done_rx;
    logic [DATA_W-1:0] dout_master;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              busy;
    logic              err_bad_cmd;

    spi_xfer_queue #(
        .DATA_W(DATA_W), .CMD_DEPTH(4), .RX_DEPTH(4), .GAP_CYCLES(GAP_CYCLES), .WAIT_DUR(8'd10)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_req(s_req),
        .s_data(s_data), .req(req), .din_master(din_master), .wait_duration(wait_duration),
        .done_tx(done_tx), .done_rx(done_rx), .dout_master(dout_master), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .busy(busy), .err_bad_cmd(err_bad_cmd)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W+1:0] iss_q[$];   // expected {req, din} of each issued transfer
    logic [DATA_W-1:0] exp_q[$];   // expected RX bytes in order
    logic [DATA_W-1:0] miso_q[$];  // bytes the master model will return
    int xfer_cnt   = 0;
    int rx_pop_cnt = 0;
    int pop_budget = BIG;
    int respond_en = 1;
    int tx_lat = 16, rx_lat = 4, rx_hold = 1;
    int low_cnt = 0;
    bit have_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_cmd(input logic [1:0] r, input logic [DATA_W-1:0] d);
        int t;
        s_valid = 1'b1;
        s_req   = r;
        s_data  = d;
        t = 0;
        while (!s_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("push_timeout", 32'(t < 2000), 32'd1);
        if (r != 2'd0) iss_q.push_back({r, d});
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_rx_drained();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("rx_drain", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- SPI master model ----------------
    logic [1:0]        cur_req;
    logic [DATA_W-1:0] cur_din;
    logic [DATA_W-1:0] cur_byte;

    task automatic run_xfer();
        int c, last, e;
        bit got_rx;
        c = (cur_req == 2'd1) ? tx_lat : (cur_req == 2'd2) ? rx_lat :
            ((tx_lat > rx_lat) ? tx_lat : rx_lat);
        e = c;
        if (cur_req[1] && (rx_lat + rx_hold - 1) > e) e = rx_lat + rx_hold - 1;
        last = e + 1;
        got_rx = 1'b0;
        low_cnt = 0;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (k == c) begin
                check("hold_req", 32'(req), 32'(cur_req));
                check("hold_din", 32'(din_master), 32'(cur_din));
            end
            if (k == c + 1) check("req_drop", 32'(req), 32'd0);
            if (k > c && req == 2'd0) low_cnt++;
            done_tx = cur_req[0] && (k == tx_lat);
            done_rx = cur_req[1] && (k >= rx_lat) && (k < rx_lat + rx_hold);
            if (done_rx) begin
                if (!got_rx) begin
                    cur_byte = (miso_q.size() != 0) ? miso_q.pop_front() : DATA_W'($urandom);
                    exp_q.push_back(cur_byte);
                    got_rx = 1'b1;
                end
                dout_master = cur_byte;
            end else begin
                dout_master = DATA_W'($urandom);
            end
        end
        done_tx = 1'b0;
        done_rx = 1'b0;
    endtask

    initial begin : responder
        logic [DATA_W+1:0] e;
        int t;
        done_tx = 1'b0;
        done_rx = 1'b0;
        dout_master = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                have_prev = 1'b0;
                low_cnt = 0;
            end else if (req == 2'd0) begin
                low_cnt++;
            end else begin
                cur_req = req;
                cur_din = din_master;
                xfer_cnt++;
                if (have_prev) check("gap_len", 32'(low_cnt >= GAP_CYCLES + 1), 32'd1);
                if (iss_q.size() == 0) begin
                    check("iss_extra", 32'(req), 32'd0);
                end else begin
                    e = iss_q.pop_front();
                    check("iss_req", 32'(req), 32'(e[DATA_W +: 2]));
                    check("iss_din", 32'(din_master), 32'(e[DATA_W-1:0]));
                end
                t = 0;
                while (respond_en == 0 && req != 2'd0 && t < 5000) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 5000) check("resp_timeout", 32'(t), 32'd0);
                if (req != 2'd0 && rst) begin
                    run_xfer();
                    have_prev = 1'b1;
                end else begin
                    have_prev = 1'b0;
                    low_cnt = 0;
                end
            end
        end
    end

    // ---------------- RX consumer ----------------
    initial begin : consumer
        logic [DATA_W-1:0] e;
        m_ready = 1'b0;
        forever begin
            @(negedge clk);
            m_ready = (pop_budget > 0) && ($urandom_range(0, 3) != 0);
            if (m_valid && m_ready && rst) begin
                if (exp_q.size() == 0) begin
                    check("rx_extra", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", 32'(m_data), 32'(e));
                end
                rx_pop_cnt++;
                pop_budget--;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin : main_seq
        int base, rbase, t;
        logic [DATA_W-1:0] mosi [5];
        mosi[0] = 8'h3C; mosi[1] = 8'hA5; mosi[2] = 8'h01; mosi[3] = 8'hFF; mosi[4] = 8'h80;
        rst = 1'b0;
        s_valid = 1'b0;
        s_req = 2'd0;
        s_data = '0;
        repeat (3) @(negedge clk);
        check("rst_req", 32'(req), 32'd0);
        check("rst_din", 32'(din_master), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_bad_cmd), 32'd0);
        check("rst_wait_dur", 32'(wait_duration), 32'd10);
        rst = 1'b1;
        @(negedge clk);

        // MOSI stream
        tx_lat = 16;
        base = xfer_cnt;
        rbase = rx_pop_cnt;
        for (int i = 0; i < 5; i++) push_cmd(2'd1, mosi[i]);
        wait_idle();
        check("mosi_count", 32'(xfer_cnt - base), 32'd5);
        check("mosi_no_rx", 32'(m_valid), 32'd0);
        check("mosi_rx_pops", 32'(rx_pop_cnt - rbase), 32'd0);
        check("mosi_iss_left", 32'(iss_q.size()), 32'd0);

        // MISO capture with done_rx held 3 cycles
        miso_q = '{8'h5A, 8'hC3, 8'h7E};
        rx_lat = 5;
        rx_hold = 3;
        base = xfer_cnt;
        rbase = rx_pop_cnt;
        for (int i = 0; i < 3; i++) push_cmd(2'd2, DATA_W'($urandom));
        wait_idle();
        wait_rx_drained();
        repeat (10) @(negedge clk);
        check("miso_count", 32'(xfer_cnt - base), 32'd3);
        check("miso_pops", 32'(rx_pop_cnt - rbase), 32'd3);
        check("miso_empty", 32'(m_valid), 32'd0);

        // Full duplex, done_rx two cycles before done_tx
        tx_lat = 8;
        rx_lat = 6;
        rx_hold = 1;
        miso_q = '{8'hE1};
        rbase = rx_pop_cnt;
        push_cmd(2'd3, 8'h96);
        wait_idle();
        wait_rx_drained();
        repeat (10) @(negedge clk);
        check("fdx_pops", 32'(rx_pop_cnt - rbase), 32'd1);

        // Backpressure on the RX side
        rx_lat = 3;
        pop_budget = 0;
        base = xfer_cnt;
        rbase = rx_pop_cnt;
        for (int i = 0; i < 5; i++) push_cmd(2'd2, DATA_W'($urandom));
        t = 0;
        while ((xfer_cnt - base) < 4 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (40) @(negedge clk);
        check("bp_issued", 32'(xfer_cnt - base), 32'd4);
        check("bp_req_idle", 32'(req), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_m_valid", 32'(m_valid), 32'd1);
        pop_budget = 1;
        t = 0;
        while ((xfer_cnt - base) < 5 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("bp_fifth", 32'(xfer_cnt - base), 32'd5);
        pop_budget = BIG;
        wait_idle();
        wait_rx_drained();
        check("bp_pops", 32'(rx_pop_cnt - rbase), 32'd5);

        // Command FIFO full with done withheld, then an illegal command
        respond_en = 0;
        tx_lat = 6;
        base = xfer_cnt;
        for (int i = 0; i < 5; i++) push_cmd(2'd1, DATA_W'(8'h40 + i));
        check("full_s_ready", 32'(s_ready), 32'd0);
        repeat (5) @(negedge clk);
        check("full_s_ready_hold", 32'(s_ready), 32'd0);
        check("full_req", 32'(req), 32'd1);
        respond_en = 1;
        wait_idle();
        check("full_count", 32'(xfer_cnt - base), 32'd5);
        check("err_before", 32'(err_bad_cmd), 32'd0);
        base = xfer_cnt;
        push_cmd(2'd0, 8'h11);
        push_cmd(2'd1, 8'h22);
        wait_idle();
        check("err_set", 32'(err_bad_cmd), 32'd1);
        check("err_count", 32'(xfer_cnt - base), 32'd1);

        // Reset in the middle of a transfer with 3 commands queued
        respond_en = 0;
        for (int i = 0; i < 4; i++) push_cmd(2'd1, DATA_W'(8'h10 + i));
        check("rst_pre_req", 32'(req), 32'd1);
        @(negedge clk);
        base = xfer_cnt;
        rst = 1'b0;
        #1;
        check("rst_async_req", 32'(req), 32'd0);
        iss_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rel_s_ready", 32'(s_ready), 32'd1);
        check("rel_m_valid", 32'(m_valid), 32'd0);
        check("rel_busy", 32'(busy), 32'd0);
        check("rel_err", 32'(err_bad_cmd), 32'd0);
        respond_en = 1;
        repeat (40) @(negedge clk);
        check("rel_no_stale", 32'(xfer_cnt - base), 32'd0);
        check("rel_req", 32'(req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
